trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 clk_i  in  1  single clock; all state on rising edge.
REQ-002 rst_i  in  1  reset, asynchronous, active-low.
REQ-003 exc_valid_i  in  1; exc_cause_i  in  4; exc_pc_i  in  32; exc_tval_i  in  32: synchronous exception request, faulting PC and trap value.
REQ-004 irq_ext_i, irq_sw_i, irq_timer_i  in  1 each: level interrupt lines; irq_pc_i  in  32: PC of next unexecuted instruction.
REQ-005 mret_i  in  1: MRET executing.
REQ-006 mstatus_i, mie_i, mtvec_i, mepc_i  in  32 each: current CSR contents.
REQ-007 we_exc_o  out  1; mcause_d_o, mepc_d_o, mtval_d_o, mstatus_d_o  out  32 each: CSR trap-update port.
REQ-008 redirect_o  out  1; redirect_pc_o  out  32: fetch redirect.
REQ-009 stall_o  out  1: pipeline hold.
REQ-010 mip_o  out  32: pending vector, bit 3 = irq_sw_i, bit 7 = irq_timer_i, bit 11 = irq_ext_i, all other bits 0; combinational from inputs.

Function
REQ-011 FSM states: IDLE, SAVE, REDIRECT, RESTORE; requests are sampled only in IDLE and ignored in all other states.
REQ-012 IDLE priority, highest first: exc_valid_i, enabled interrupt, mret_i.
REQ-013 Interrupt enabled = mstatus_i[3] AND mie_i[n] AND line n; among enabled lines: ext (11) > sw (3) > timer (7).
REQ-014 IDLE + exception or enabled interrupt -> SAVE; IDLE + mret_i -> RESTORE; otherwise stay IDLE.
REQ-015 Latched in IDLE: cause, mepc (exc_pc_i for exception, irq_pc_i for interrupt), tval (exc_tval_i for exception, 0 for interrupt).
REQ-016 SAVE: we_exc_o = 1 for exactly one cycle.
REQ-017 SAVE outputs: mcause_d_o = {interrupt, 27'b0, cause}; mepc_d_o[1:0] forced to 00.
REQ-018 SAVE mstatus_d_o: mstatus_i with MPIE[7] = MIE[3], MIE[3] = 0, MPP[12:11] = 11.
REQ-019 SAVE -> REDIRECT.
REQ-020 REDIRECT: redirect_o = 1 for one cycle, redirect_pc_o = {mtvec_i[31:2], 2'b00} (see REQ-028); REDIRECT -> IDLE.
REQ-021 RESTORE: we_exc_o = 1; mstatus_d_o has MIE = MPIE, MPIE = 1, MPP = 11; mcause_d_o and mepc_d_o equal the current CSR values; redirect_o = 1 with redirect_pc_o = mepc_i; RESTORE -> IDLE.
REQ-022 stall_o = 1 in SAVE, REDIRECT and RESTORE, and in the IDLE cycle in which a request is accepted (combinational).
REQ-023 Exception and mret_i in the same cycle: exception taken, MRET dropped.
REQ-024 Interrupt line deasserting after acceptance: trap completes unchanged.
REQ-025 Trap latency: request cycle -> we_exc_o at +1 -> redirect_o at +2. MRET latency: redirect_o at +1.

Reset
REQ-026 rst_i low: FSM -> IDLE immediately; all registered outputs and latches -> 0, including mid-trap.
REQ-027 Trap or MRET in flight at reset is discarded with no partial CSR write after release.

Configuration
REQ-028 Macro TRAP_VECTORED_EN defined: for interrupts with mtvec_i[1:0] = 01, redirect_pc_o = base + 4*cause. Exceptions always use the base address.
REQ-029 Macro TRAP_VECTORED_EN undefined: mtvec_i[1:0] is ignored and redirect_pc_o = base for all traps.

Structure
REQ-030 Package trap_pkg holds: state enum, cause codes (MSI = 3, MTI = 7, MEI = 11), mstatus bit positions (MIE, MPIE, MPP).
REQ-031 Sub-module trap_irq_sel: combinational enable/priority encoder for REQ-013, outputs valid + 4-bit cause.

Verification
REQ-032 Illegal instruction: exc_valid_i = 1, cause = 2, pc = 0x100, tval = 0xDEAD; mtvec = 0x800; mstatus = 0x8 -> next cycle we_exc_o = 1 with mcause 0x2, mepc 0x100, mtval 0xDEAD, mstatus 0x1880; following cycle redirect_pc_o = 0x800.
REQ-033 Timer interrupt: mstatus = 0x8, mie = 0x80, irq_timer_i = 1, irq_pc_i = 0x204, mtvec = 0x801, TRAP_VECTORED_EN defined -> mcause 0x80000007, mepc 0x204, redirect_pc_o = 0x81C; same stimulus with macro undefined -> redirect_pc_o = 0x800.
REQ-034 Masking and priority: mstatus = 0 with all lines high -> no trap. mstatus = 0x8, mie = 0x888, all lines high -> cause 11.
REQ-035 MRET: mstatus = 0x1880, mepc = 0x104, mret_i = 1 -> next cycle mstatus_d_o = 0x1888, redirect_pc_o = 0x104.
REQ-036 Simultaneous exception + mret_i -> exception path only. rst_i low during SAVE -> we_exc_o = 0 and redirect_o never asserted.

Source files
------------

// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared types, cause codes and mstatus field helpers for trap_ctrl
package trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SAVE     = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_RESTORE  = 2'd3
    } trap_state_e;

    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Trap entry: stash MIE in MPIE, mask interrupts, record machine mode as previous.
    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] ms);
        logic [31:0] r;
        r = ms;
        r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    // Trap return: MIE comes back from MPIE, MPIE re-armed, previous mode stays machine.
    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] ms);
        logic [31:0] r;
        r = ms;
        r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/trap_irq_sel.sv
// rtl/trap_irq_sel.sv - interrupt enable masking and fixed-priority cause encoder
module trap_irq_sel
    import trap_pkg::*;
(
    input  logic       mstatus_mie_i,
    input  logic       mie_ext_i,
    input  logic       mie_sw_i,
    input  logic       mie_timer_i,
    input  logic       irq_ext_i,
    input  logic       irq_sw_i,
    input  logic       irq_timer_i,
    output logic       valid_o,
    output logic [3:0] cause_o
);

    logic en_ext;
    logic en_sw;
    logic en_timer;

    assign en_ext   = mstatus_mie_i & mie_ext_i   & irq_ext_i;
    assign en_sw    = mstatus_mie_i & mie_sw_i    & irq_sw_i;
    assign en_timer = mstatus_mie_i & mie_timer_i & irq_timer_i;

    // Priority among enabled lines: external, then software, then timer.
    always_comb begin
        valid_o = 1'b1;
        cause_o = 4'd0;
        if (en_ext) begin
            cause_o = CAUSE_MEI;
        end else if (en_sw) begin
            cause_o = CAUSE_MSI;
        end else if (en_timer) begin
            cause_o = CAUSE_MTI;
        end else begin
            valid_o = 1'b0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap/MRET sequencer; TRAP_VECTORED_EN enables vectored interrupt targets
module trap_ctrl
    import trap_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        exc_valid_i,
    input  logic [3:0]  exc_cause_i,
    input  logic [31:0] exc_pc_i,
    input  logic [31:0] exc_tval_i,
    input  logic        irq_ext_i,
    input  logic        irq_sw_i,
    input  logic        irq_timer_i,
    input  logic [31:0] irq_pc_i,
    input  logic        mret_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mie_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic        we_exc_o,
    output logic [31:0] mcause_d_o,
    output logic [31:0] mepc_d_o,
    output logic [31:0] mtval_d_o,
    output logic [31:0] mstatus_d_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        stall_o,
    output logic [31:0] mip_o
);

    trap_state_e state_q, state_d;
    logic        irq_q, irq_d;
    logic [3:0]  cause_q, cause_d;
    logic [29:0] epc_q, epc_d;
    logic [31:0] tval_q, tval_d;

    logic        irq_valid;
    logic [3:0]  irq_cause;
    logic [31:0] trap_base;
    logic [31:0] trap_target;
    logic        unused_bits;

    trap_irq_sel u_irq_sel (
        .mstatus_mie_i (mstatus_i[MSTATUS_MIE]),
        .mie_ext_i     (mie_i[CAUSE_MEI]),
        .mie_sw_i      (mie_i[CAUSE_MSI]),
        .mie_timer_i   (mie_i[CAUSE_MTI]),
        .irq_ext_i     (irq_ext_i),
        .irq_sw_i      (irq_sw_i),
        .irq_timer_i   (irq_timer_i),
        .valid_o       (irq_valid),
        .cause_o       (irq_cause)
    );

    assign mip_o = {20'b0, irq_ext_i, 3'b0, irq_timer_i, 3'b0, irq_sw_i, 3'b0};

    assign trap_base = {mtvec_i[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    assign trap_target = (irq_q && (mtvec_i[1:0] == 2'b01))
                       ? trap_base + {26'b0, cause_q, 2'b00}
                       : trap_base;
    assign unused_bits = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0],
                           exc_pc_i[1:0], irq_pc_i[1:0]};
`else
    assign trap_target = trap_base;
    assign unused_bits = ^{mie_i[31:12], mie_i[10:8], mie_i[6:4], mie_i[2:0],
                           exc_pc_i[1:0], irq_pc_i[1:0], mtvec_i[1:0], cause_q[3]};
`endif

    // State and trap latches; reset abandons any trap or MRET in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
            cause_q <= 4'd0;
            epc_q   <= 30'd0;
            tval_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            tval_q  <= tval_d;
        end
    end

    // Next state: requests are only looked at in IDLE; stall covers the accepting cycle.
    always_comb begin
        state_d = state_q;
        irq_d   = irq_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        tval_d  = tval_q;
        stall_o = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                stall_o = 1'b0;
                if (exc_valid_i) begin
                    state_d = ST_SAVE;
                    irq_d   = 1'b0;
                    cause_d = exc_cause_i;
                    epc_d   = exc_pc_i[31:2];
                    tval_d  = exc_tval_i;
                    stall_o = 1'b1;
                end else if (irq_valid) begin
                    state_d = ST_SAVE;
                    irq_d   = 1'b1;
                    cause_d = irq_cause;
                    epc_d   = irq_pc_i[31:2];
                    tval_d  = 32'd0;
                    stall_o = 1'b1;
                end else if (mret_i) begin
                    state_d = ST_RESTORE;
                    stall_o = 1'b1;
                end
            end
            ST_SAVE:     state_d = ST_REDIRECT;
            ST_REDIRECT: state_d = ST_IDLE;
            ST_RESTORE:  state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // CSR write port and fetch redirect, driven purely from the current state.
    always_comb begin
        we_exc_o      = 1'b0;
        mcause_d_o    = 32'd0;
        mepc_d_o      = 32'd0;
        mtval_d_o     = 32'd0;
        mstatus_d_o   = 32'd0;
        redirect_o    = 1'b0;
        redirect_pc_o = 32'd0;
        unique case (state_q)
            ST_SAVE: begin
                we_exc_o    = 1'b1;
                mcause_d_o  = {irq_q, 27'b0, cause_q};
                mepc_d_o    = {epc_q, 2'b00};
                mtval_d_o   = tval_q;
                mstatus_d_o = mstatus_on_trap(mstatus_i);
            end
            ST_REDIRECT: begin
                redirect_o    = 1'b1;
                redirect_pc_o = trap_target;
            end
            ST_RESTORE: begin
                we_exc_o      = 1'b1;
                mcause_d_o    = {irq_q, 27'b0, cause_q};
                mepc_d_o      = mepc_i;
                mtval_d_o     = tval_q;
                mstatus_d_o   = mstatus_on_mret(mstatus_i);
                redirect_o    = 1'b1;
                redirect_pc_o = mepc_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - randomized scoreboard bench for trap_ctrl against a behavioural trap model
module tb_trap_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        exc_valid_i = 1'b0;
    logic [3:0]  exc_cause_i = 4'd0;
    logic [31:0] exc_pc_i = 32'd0;
    logic [31:0] exc_tval_i = 32'd0;
    logic        irq_ext_i = 1'b0;
    logic        irq_sw_i = 1'b0;
    logic        irq_timer_i = 1'b0;
    logic [31:0] irq_pc_i = 32'd0;
    logic        mret_i = 1'b0;
    logic [31:0] mstatus_i = 32'd0;
    logic [31:0] mie_i = 32'd0;
    logic [31:0] mtvec_i = 32'd0;
    logic [31:0] mepc_i = 32'd0;
    logic        we_exc_o;
    logic [31:0] mcause_d_o;
    logic [31:0] mepc_d_o;
    logic [31:0] mtval_d_o;
    logic [31:0] mstatus_d_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        stall_o;
    logic [31:0] mip_o;

    trap_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i),
        .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i),
        .irq_ext_i(irq_ext_i), .irq_sw_i(irq_sw_i), .irq_timer_i(irq_timer_i),
        .irq_pc_i(irq_pc_i), .mret_i(mret_i),
        .mstatus_i(mstatus_i), .mie_i(mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .we_exc_o(we_exc_o), .mcause_d_o(mcause_d_o), .mepc_d_o(mepc_d_o),
        .mtval_d_o(mtval_d_o), .mstatus_d_o(mstatus_d_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .stall_o(stall_o), .mip_o(mip_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] mcause;
        logic [31:0] mepc;
        logic [31:0] mtval;
        logic [31:0] mstatus;
        bit          is_trap;
    } wr_t;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
    } rd_t;

    wr_t wq[$];
    rd_t rq[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Transaction description filled in before each run_txn call.
    bit          g_exc, g_ext, g_sw, g_tim, g_mret;
    logic [3:0]  g_cause;
    logic [31:0] g_pc, g_tval, g_irq_pc, g_mstatus, g_mie, g_mtvec, g_mepc;

    task automatic clr_g();
        g_exc = 0; g_ext = 0; g_sw = 0; g_tim = 0; g_mret = 0;
        g_cause = 4'd0; g_pc = 0; g_tval = 0; g_irq_pc = 0;
        g_mstatus = 0; g_mie = 0; g_mtvec = 0; g_mepc = 0;
    endtask

    task automatic clear_requests();
        exc_valid_i = 0; irq_ext_i = 0; irq_sw_i = 0; irq_timer_i = 0; mret_i = 0;
    endtask

    // Reference model: decides what the trap unit must do with one request cycle.
    task automatic run_txn();
        logic [31:0] mip_e, ms, base, target;
        int          k;
        int          pri[3];
        bit          taken, is_irq;
        logic [3:0]  c;
        wr_t         w;
        rd_t         r;
        pri[0] = 11; pri[1] = 3; pri[2] = 7;

        @(posedge clk_i); #1;
        exc_valid_i = g_exc; exc_cause_i = g_cause; exc_pc_i = g_pc; exc_tval_i = g_tval;
        irq_ext_i = g_ext; irq_sw_i = g_sw; irq_timer_i = g_tim; irq_pc_i = g_irq_pc;
        mret_i = g_mret; mstatus_i = g_mstatus; mie_i = g_mie; mtvec_i = g_mtvec; mepc_i = g_mepc;
        k = cyc;

        mip_e = 32'd0;
        mip_e[3] = g_sw; mip_e[7] = g_tim; mip_e[11] = g_ext;

        taken = 0; is_irq = 0; c = 4'd0;
        if (g_exc) begin
            taken = 1; c = g_cause;
        end else begin
            for (int i = 0; i < 3; i++)
                if (!taken && g_mstatus[3] && g_mie[pri[i]] && mip_e[pri[i]]) begin
                    taken = 1; is_irq = 1; c = 4'(pri[i]);
                end
        end

        if (taken) begin
            ms = g_mstatus;
            ms[7] = g_mstatus[3];
            ms[3] = 1'b0;
            ms[12:11] = 2'b11;
            base = g_mtvec & ~32'd3;
            target = base;
`ifdef TRAP_VECTORED_EN
            if (is_irq && g_mtvec[1:0] == 2'b01) target = base + 32'd4 * 32'(c);
`endif
            w.cyc = k + 1;
            w.mcause = (is_irq ? 32'h8000_0000 : 32'd0) | 32'(c);
            w.mepc = (is_irq ? g_irq_pc : g_pc) & ~32'd3;
            w.mtval = is_irq ? 32'd0 : g_tval;
            w.mstatus = ms;
            w.is_trap = 1;
            wq.push_back(w);
            r.cyc = k + 2; r.pc = target;
            rq.push_back(r);
        end else if (g_mret) begin
            ms = g_mstatus;
            ms[3] = g_mstatus[7];
            ms[7] = 1'b1;
            ms[12:11] = 2'b11;
            w.cyc = k + 1; w.mcause = 0; w.mepc = g_mepc; w.mtval = 0;
            w.mstatus = ms; w.is_trap = 0;
            wq.push_back(w);
            r.cyc = k + 1; r.pc = g_mepc;
            rq.push_back(r);
        end

        @(negedge clk_i);
        check("stall_accept", {31'b0, stall_o}, {31'b0, taken | g_mret});
        check("mip", mip_o, mip_e);

        @(posedge clk_i); #1;
        if (taken || g_mret) begin
            // Requests during SAVE/RESTORE must be ignored; lines may also drop here.
            exc_valid_i = 1'($urandom_range(0, 1));
            exc_cause_i = 4'($urandom);
            irq_ext_i = 1'($urandom_range(0, 1));
            irq_sw_i = 1'($urandom_range(0, 1));
            irq_timer_i = 1'($urandom_range(0, 1));
            mret_i = 1'($urandom_range(0, 1));
        end else begin
            clear_requests();
        end
        @(posedge clk_i); #1;
        clear_requests();
        repeat (2) @(posedge clk_i);
    endtask

    // Monitor: every CSR write or redirect the DUT presents must match the next expectation.
    always @(negedge clk_i) begin : monitor
        wr_t e;
        rd_t r;
        if (we_exc_o) begin
            if (wq.size() == 0) check("we_exc_unexpected", {31'b0, we_exc_o}, 32'd0);
            else begin
                e = wq.pop_front();
                check("we_cycle", cyc, e.cyc);
                check("mepc_d", mepc_d_o, e.mepc);
                check("mstatus_d", mstatus_d_o, e.mstatus);
                if (e.is_trap) begin
                    check("mcause_d", mcause_d_o, e.mcause);
                    check("mtval_d", mtval_d_o, e.mtval);
                end
            end
        end
        if (redirect_o) begin
            if (rq.size() == 0) check("redirect_unexpected", {31'b0, redirect_o}, 32'd0);
            else begin
                r = rq.pop_front();
                check("redirect_cycle", cyc, r.cyc);
                check("redirect_pc", redirect_pc_o, r.pc);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        logic [31:0] rnd;
        clr_g();
        rst_i = 0;
        repeat (2) @(negedge clk_i);
        check("reset_we", {31'b0, we_exc_o}, 32'd0);
        check("reset_redirect", {31'b0, redirect_o}, 32'd0);
        check("reset_stall", {31'b0, stall_o}, 32'd0);
        check("reset_mip", mip_o, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1;

        // Illegal instruction exception.
        clr_g(); g_exc = 1; g_cause = 4'd2; g_pc = 32'h100; g_tval = 32'hDEAD;
        g_mtvec = 32'h800; g_mstatus = 32'h8;
        run_txn();

        // Timer interrupt with vectored mtvec.
        clr_g(); g_mstatus = 32'h8; g_mie = 32'h80; g_tim = 1; g_irq_pc = 32'h204; g_mtvec = 32'h801;
        run_txn();

        // Global mask off: nothing taken.
        clr_g(); g_ext = 1; g_sw = 1; g_tim = 1; g_mie = 32'h888; g_mtvec = 32'h801;
        run_txn();

        // All enabled and pending: external wins.
        clr_g(); g_mstatus = 32'h8; g_mie = 32'h888; g_ext = 1; g_sw = 1; g_tim = 1;
        g_irq_pc = 32'h300; g_mtvec = 32'h1001;
        run_txn();

        // Software beats timer.
        clr_g(); g_mstatus = 32'h8; g_mie = 32'h088; g_ext = 1; g_sw = 1; g_tim = 1;
        g_irq_pc = 32'h402; g_mtvec = 32'h2001;
        run_txn();

        // MRET.
        clr_g(); g_mstatus = 32'h1880; g_mepc = 32'h104; g_mret = 1;
        run_txn();

        // Exception together with MRET: exception only.
        clr_g(); g_exc = 1; g_cause = 4'd5; g_pc = 32'h55; g_tval = 32'h1234; g_mret = 1;
        g_mepc = 32'h900; g_mstatus = 32'h80; g_mtvec = 32'hA01;
        run_txn();

        // Reset asserted while in SAVE: the trap vanishes entirely.
        clr_g();
        @(posedge clk_i); #1;
        exc_valid_i = 1; exc_cause_i = 4'd4; exc_pc_i = 32'h700; mtvec_i = 32'h800;
        @(posedge clk_i); #1;
        clear_requests();
        rst_i = 0;
        #1;
        check("rst_save_we", {31'b0, we_exc_o}, 32'd0);
        check("rst_save_redirect", {31'b0, redirect_o}, 32'd0);
        check("rst_save_stall", {31'b0, stall_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1;
        repeat (4) @(posedge clk_i);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            clr_g();
            g_exc = ($urandom_range(0, 3) == 0);
            g_cause = 4'($urandom);
            g_pc = $urandom; g_tval = $urandom; g_irq_pc = $urandom;
            g_ext = 1'($urandom_range(0, 1));
            g_sw = 1'($urandom_range(0, 1));
            g_tim = 1'($urandom_range(0, 1));
            g_mret = ($urandom_range(0, 2) == 0);
            g_mstatus = $urandom;
            g_mie = $urandom;
            rnd = $urandom;
            g_mtvec = (rnd & ~32'd3) | 32'($urandom_range(0, 1));
            g_mepc = $urandom;
            run_txn();
        end

        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        check("pending_writes", wq.size(), 32'd0);
        check("pending_redirects", rq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
